// File: rtl/fifo_shift_level.sv
// Shift-register FIFO with occupancy count, almost-full/almost-empty thresholds and flush.
// Optional sticky overflow/underflow flags are built when FIFO_SHIFT_LEVEL_ERRFLAGS_EN is defined.
module fifo_shift_level #(
    parameter int unsigned W_WRITE       = 32,
    parameter int unsigned C_NUMBERWORDS = 8,
    parameter int unsigned C_AFULL       = C_NUMBERWORDS - 1,
    parameter int unsigned C_AEMPTY      = 1
) (
    input  logic                                 sClk_i,
    input  logic                                 snRst_i,
    input  logic                                 Clear_i,
    input  logic                                 Write_i,
    input  logic [W_WRITE-1:0]                   WriteData_i,
    input  logic                                 Read_i,
    output logic [W_WRITE-1:0]                   ReadData_oc,
    output logic                                 Empty_oc,
    output logic                                 Full_oc,
    output logic                                 AlmostFull_oc,
    output logic                                 AlmostEmpty_oc,
    output logic [$clog2(C_NUMBERWORDS+1)-1:0]   Count_oc,
    output logic                                 Overflow_o,
    output logic                                 Underflow_o
);

    localparam int unsigned CW = $clog2(C_NUMBERWORDS + 1);
    localparam logic [CW-1:0] DepthC  = CW'(C_NUMBERWORDS);
    localparam logic [CW-1:0] AFullC  = CW'(C_AFULL);
    localparam logic [CW-1:0] AEmptyC = CW'(C_AEMPTY);

    logic [W_WRITE-1:0] mem_q     [C_NUMBERWORDS];
    logic [W_WRITE-1:0] mem_d     [C_NUMBERWORDS];
    logic [W_WRITE-1:0] shift_src [C_NUMBERWORDS];

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] wr_idx;
    logic          empty_q, full_q, afull_q, aempty_q;
    logic          read_en, write_en;

    assign read_en  = Read_i & ~empty_q;
    assign write_en = Write_i & (~full_q | read_en);

    // With a simultaneous pop the new word lands one slot lower, behind the shifted data.
    assign wr_idx = read_en ? (count_q - CW'(1)) : count_q;

    // Top slot has no upper neighbour; it keeps its (now stale) contents on a shift.
    for (genvar k = 0; k < C_NUMBERWORDS; k++) begin : g_shift
        if (k < C_NUMBERWORDS - 1) begin : g_mid
            assign shift_src[k] = mem_q[k+1];
        end else begin : g_top
            assign shift_src[k] = mem_q[k];
        end
    end

    always_comb begin
        for (int k = 0; k < C_NUMBERWORDS; k++) begin
            mem_d[k] = read_en ? shift_src[k] : mem_q[k];
            if (write_en && (wr_idx == CW'(k))) begin
                mem_d[k] = WriteData_i;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({write_en, read_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately not reset; Count and the flags define what is valid.
    always_ff @(posedge sClk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge sClk_i) begin
        if (!snRst_i || Clear_i) begin
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == DepthC);
            afull_q  <= (count_d >= AFullC);
            aempty_q <= (count_d <= AEmptyC);
        end
    end

`ifdef FIFO_SHIFT_LEVEL_ERRFLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge sClk_i) begin
        if (!snRst_i || Clear_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (Write_i && !write_en) overflow_q  <= 1'b1;
            if (Read_i && empty_q)    underflow_q <= 1'b1;
        end
    end

    assign Overflow_o  = overflow_q;
    assign Underflow_o = underflow_q;
`else
    assign Overflow_o  = 1'b0;
    assign Underflow_o = 1'b0;
`endif

    assign ReadData_oc    = empty_q ? '0 : mem_q[0];
    assign Empty_oc       = empty_q;
    assign Full_oc        = full_q;
    assign AlmostFull_oc  = afull_q;
    assign AlmostEmpty_oc = aempty_q;
    assign Count_oc       = count_q;

endmodule

// File: tb/tb_fifo_shift_level.sv
// Bench for fifo_shift_level: vector table on a depth-4 instance, hand sequences for
// flush/reset/depth-1, and a queue-based scoreboard under random traffic.
module tb_fifo_shift_level;

`ifdef FIFO_SHIFT_LEVEL_ERRFLAGS_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // depth-4 instance
    logic       clr4, wr4, rd4;
    logic [7:0] wd4, rdata4;
    logic       emp4, full4, af4, ae4, ov4, un4;
    logic [2:0] cnt4;

    // depth-1 instance
    logic       clr1, wr1, rd1;
    logic [7:0] wd1, rdata1;
    logic       emp1, full1, af1, ae1, ov1, un1;
    logic [0:0] cnt1;

    fifo_shift_level #(
        .W_WRITE(8), .C_NUMBERWORDS(4), .C_AFULL(3), .C_AEMPTY(1)
    ) u_dut4 (
        .sClk_i(clk), .snRst_i(rst_n), .Clear_i(clr4), .Write_i(wr4), .WriteData_i(wd4),
        .Read_i(rd4), .ReadData_oc(rdata4), .Empty_oc(emp4), .Full_oc(full4),
        .AlmostFull_oc(af4), .AlmostEmpty_oc(ae4), .Count_oc(cnt4),
        .Overflow_o(ov4), .Underflow_o(un4)
    );

    fifo_shift_level #(
        .W_WRITE(8), .C_NUMBERWORDS(1), .C_AFULL(1), .C_AEMPTY(0)
    ) u_dut1 (
        .sClk_i(clk), .snRst_i(rst_n), .Clear_i(clr1), .Write_i(wr1), .WriteData_i(wd1),
        .Read_i(rd1), .ReadData_oc(rdata1), .Empty_oc(emp1), .Full_oc(full1),
        .AlmostFull_oc(af1), .AlmostEmpty_oc(ae1), .Count_oc(cnt1),
        .Overflow_o(ov1), .Underflow_o(un1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       clr, wr, rd;
        logic [7:0] wd;
        int         cnt;
        logic       emp, full, af, ae;
        logic [7:0] rdata;
        logic       ov, un;  // expected only when error flags are built
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic clr, input logic wr, input logic [7:0] wd,
                                input logic rd, input int cnt, input logic emp,
                                input logic full, input logic af, input logic ae,
                                input logic [7:0] rdata, input logic ov, input logic un);
        vec_t v;
        v.clr = clr; v.wr = wr; v.wd = wd; v.rd = rd; v.cnt = cnt; v.emp = emp;
        v.full = full; v.af = af; v.ae = ae; v.rdata = rdata; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic check_reset4(input string tag);
        check({tag, ".cnt"},   32'(cnt4), 0);
        check({tag, ".emp"},   32'(emp4), 1);
        check({tag, ".full"},  32'(full4), 0);
        check({tag, ".af"},    32'(af4), 0);
        check({tag, ".ae"},    32'(ae4), 1);
        check({tag, ".ov"},    32'(ov4), 0);
        check({tag, ".un"},    32'(un4), 0);
        check({tag, ".rdata"}, 32'(rdata4), 0);
    endtask

    initial begin
        logic [7:0] model[$];
        rst_n = 1'b0;
        {clr4, wr4, rd4, wd4} = '0;
        {clr1, wr1, rd1, wd1} = '0;

        //      clr wr  wd     rd cnt emp full af ae rdata  ov un
        vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 0, 0, 1, 8'h11, 0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 2, 0, 0, 0, 0, 8'h11, 0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 3, 0, 0, 1, 0, 8'h11, 0, 0));
        vecs.push_back(mk(0, 1, 8'h44, 0, 4, 0, 1, 1, 0, 8'h11, 0, 0));
        vecs.push_back(mk(0, 1, 8'h99, 0, 4, 0, 1, 1, 0, 8'h11, 1, 0));
        vecs.push_back(mk(0, 1, 8'h55, 1, 4, 0, 1, 1, 0, 8'h22, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 3, 0, 0, 1, 0, 8'h33, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 2, 0, 0, 0, 0, 8'h44, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 8'h55, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1, 8'h66, 0, 1, 0, 0, 0, 1, 8'h66, 1, 1));
        vecs.push_back(mk(0, 1, 8'h77, 0, 2, 0, 0, 0, 0, 8'h66, 1, 1));
        vecs.push_back(mk(0, 1, 8'h88, 0, 3, 0, 0, 1, 0, 8'h66, 1, 1));
        vecs.push_back(mk(1, 1, 8'h12, 0, 0, 1, 0, 0, 1, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h00, 0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h00, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check_reset4("reset4");
        check("reset1.cnt", 32'(cnt1), 0);
        check("reset1.emp", 32'(emp1), 1);
        check("reset1.ae",  32'(ae1), 1);
        check("reset1.rdata", 32'(rdata1), 0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clr4 = vecs[i].clr; wr4 = vecs[i].wr; wd4 = vecs[i].wd; rd4 = vecs[i].rd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.cnt", i),   32'(cnt4),   32'(vecs[i].cnt));
            check($sformatf("vec%0d.emp", i),   32'(emp4),   32'(vecs[i].emp));
            check($sformatf("vec%0d.full", i),  32'(full4),  32'(vecs[i].full));
            check($sformatf("vec%0d.af", i),    32'(af4),    32'(vecs[i].af));
            check($sformatf("vec%0d.ae", i),    32'(ae4),    32'(vecs[i].ae));
            check($sformatf("vec%0d.rdata", i), 32'(rdata4), 32'(vecs[i].rdata));
            check($sformatf("vec%0d.ov", i),    32'(ov4),    32'(ErrEn & vecs[i].ov));
            check($sformatf("vec%0d.un", i),    32'(un4),    32'(ErrEn & vecs[i].un));
        end

        // Reset in the middle of a burst drops everything.
        @(negedge clk);
        {clr4, rd4} = '0; wr4 = 1'b1; wd4 = 8'h21;
        @(negedge clk);
        wd4 = 8'h31;
        @(posedge clk);
        #1;
        check("burst.cnt", 32'(cnt4), 2);
        @(negedge clk);
        rst_n = 1'b0; rd4 = 1'b1; wd4 = 8'h41;
        @(posedge clk);
        #1;
        check_reset4("midreset");
        @(negedge clk);
        rst_n = 1'b1; {wr4, rd4} = '0;

        // Depth-1 FIFO: write, then simultaneous read+write when full.
        @(negedge clk);
        wr1 = 1'b1; wd1 = 8'hA5;
        @(posedge clk);
        #1;
        check("d1.wr.full",  32'(full1), 1);
        check("d1.wr.cnt",   32'(cnt1), 1);
        check("d1.wr.ae",    32'(ae1), 0);
        check("d1.wr.af",    32'(af1), 1);
        check("d1.wr.rdata", 32'(rdata1), 32'h A5);
        @(negedge clk);
        rd1 = 1'b1; wd1 = 8'h5A;
        check("d1.rw.pre",   32'(rdata1), 32'h A5);
        @(posedge clk);
        #1;
        check("d1.rw.full",  32'(full1), 1);
        check("d1.rw.rdata", 32'(rdata1), 32'h5A);
        @(negedge clk);
        wr1 = 1'b0;
        @(posedge clk);
        #1;
        check("d1.rd.emp",   32'(emp1), 1);
        check("d1.rd.rdata", 32'(rdata1), 0);
        check("d1.ov",       32'(ov1), 0);
        check("d1.un",       32'(un1), 0);
        @(negedge clk);
        rd1 = 1'b0;

        // Random traffic against a queue model of the depth-4 FIFO.
        for (int c = 0; c < 400; c++) begin
            logic r, w, ren, wen;
            logic [7:0] d;
            @(negedge clk);
            check($sformatf("sb%0d.cnt", c), 32'(cnt4), 32'(model.size()));
            check($sformatf("sb%0d.rdata", c), 32'(rdata4),
                  (model.size() != 0) ? 32'(model[0]) : 32'h0);
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            clr4 = 1'b0; rd4 = r; wr4 = w; wd4 = d;
            ren = r && (model.size() != 0);
            wen = w && ((model.size() < 4) || ren);
            if (ren) void'(model.pop_front());
            if (wen) model.push_back(d);
            @(posedge clk);
        end
        @(negedge clk);
        {wr4, rd4} = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
